// File: rtl/array_index_pipeline.sv
// Two-stage valid/ready pipelined reader for a flattened array; out-of-range
// indices clamp to the last element and raise out_oob.
module array_index_pipeline #(
    parameter int unsigned ELEM_WIDTH = 33,
    parameter int unsigned NUM_ELEMS  = 4,
    parameter int unsigned IDX_WIDTH  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] x,
    input  logic [IDX_WIDTH-1:0]            idx,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [ELEM_WIDTH-1:0]           out,
    output logic                            out_oob,
    output logic                            out_valid,
    input  logic                            out_ready
);

    // One extra bit so the compare still works when 2**IDX_WIDTH == NUM_ELEMS.
    localparam logic [IDX_WIDTH:0] NumElemsExt = (IDX_WIDTH + 1)'(NUM_ELEMS);

    logic                            p0_valid;
    logic [NUM_ELEMS*ELEM_WIDTH-1:0] p0_x;
    logic [IDX_WIDTH-1:0]            p0_idx;
    logic                            p1_valid;
    logic [ELEM_WIDTH-1:0]           p1_data;
    logic                            p1_oob;

    logic                            p0_ready;
    logic                            p1_ready;
    logic [ELEM_WIDTH-1:0]           sel_data;
    logic                            sel_oob;

    assign p1_ready = !p1_valid || out_ready;
    assign p0_ready = !p0_valid || p1_ready;
    assign in_ready = p0_ready;

    always_comb begin
        sel_oob  = ({1'b0, p0_idx} >= NumElemsExt);
        sel_data = p0_x[(NUM_ELEMS-1)*ELEM_WIDTH +: ELEM_WIDTH];
        if (!sel_oob) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                if (p0_idx == IDX_WIDTH'(i)) begin
                    sel_data = p0_x[i*ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_valid <= 1'b0;
            p0_x     <= '0;
            p0_idx   <= '0;
        end else if (p0_ready) begin
            p0_valid <= in_valid;
            if (in_valid) begin
                p0_x   <= x;
                p0_idx <= idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p1_data  <= '0;
            p1_oob   <= 1'b0;
        end else if (p1_ready) begin
            p1_valid <= p0_valid;
            if (p0_valid) begin
                p1_data <= sel_data;
                p1_oob  <= sel_oob;
            end
        end
    end

    assign out       = p1_data;
    assign out_oob   = p1_oob;
    assign out_valid = p1_valid;

endmodule

// File: tb/tb_array_index_pipeline.sv
// Directed and scoreboard-checked bench for array_index_pipeline. Inputs change
// at the falling edge; outputs and handshakes are observed 1 time unit later.
module tb_array_index_pipeline;

    localparam int EW = 33;
    localparam int NE = 4;
    localparam int IW = 3;

    localparam logic [EW-1:0] E0 = 33'h1_ffff_ffff;
    localparam logic [EW-1:0] E1 = 33'h0_1234_5678;
    localparam logic [EW-1:0] E2 = 33'h0_0000_002a;
    localparam logic [EW-1:0] E3 = 33'h1_0000_0003;
    localparam logic [NE*EW-1:0] XV = {E3, E2, E1, E0};

    logic              clk;
    logic              rst_n;
    logic [NE*EW-1:0]  x;
    logic [IW-1:0]     idx;
    logic              in_valid;
    logic              in_ready;
    logic [EW-1:0]     out;
    logic              out_oob;
    logic              out_valid;
    logic              out_ready;

    int total;
    int bad;

    array_index_pipeline #(
        .ELEM_WIDTH(EW),
        .NUM_ELEMS (NE),
        .IDX_WIDTH (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .idx      (idx),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_oob  (out_oob),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = XV;
        idx       = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out !== '0 || out_oob !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b out=%h oob=%b want 0/0/0",
                     out_valid, out, out_oob);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [EW-1:0] exp_d;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid  = (c == 0);
            idx       = 3'd1;
            out_ready = 1'b1;
            #1;
            exp_d = E1;
            total++;
            if (out_valid !== (c == 2)) begin
                bad++;
                $display("FAIL basic_valid c=%0d: got %b want %b", c, out_valid, (c == 2));
            end
            if (c == 2) begin
                total++;
                if (out !== exp_d || out_oob !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_data: got %h oob=%b want %h oob=0", out, out_oob, exp_d);
                end
            end
        end
    endtask

    task automatic test_stream;
        logic [EW-1:0] exp_tab [4];
        exp_tab[0] = E0; exp_tab[1] = E1; exp_tab[2] = E2; exp_tab[3] = E3;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            in_valid  = (c < 4);
            idx       = IW'(c);
            out_ready = 1'b1;
            #1;
            total++;
            if (out_valid !== (c >= 2 && c < 6)) begin
                bad++;
                $display("FAIL stream_valid c=%0d: got %b", c, out_valid);
            end else if (c >= 2 && c < 6) begin
                total++;
                if (out !== exp_tab[c-2] || out_oob !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_data c=%0d: got %h oob=%b want %h oob=0",
                             c, out, out_oob, exp_tab[c-2]);
                end
            end
        end
    endtask

    task automatic test_oob;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid  = (c < 2);
            idx       = (c == 0) ? 3'd4 : 3'd7;
            out_ready = 1'b1;
            #1;
            if (c == 2 || c == 3) begin
                total++;
                if (out_valid !== 1'b1 || out !== E3 || out_oob !== 1'b1) begin
                    bad++;
                    $display("FAIL oob c=%0d: got valid=%b out=%h oob=%b want 1/%h/1",
                             c, out_valid, out, out_oob, E3);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [EW-1:0] exp_tab [4];
        logic          exp_rdy  [12];
        int            exp_item [12];
        int            k;
        exp_tab[0] = E0; exp_tab[1] = E1; exp_tab[2] = E2; exp_tab[3] = E3;
        for (int c = 0; c < 12; c++) begin
            exp_rdy[c]  = !(c >= 2 && c <= 6);
            exp_item[c] = (c < 2) ? -1 : (c <= 7) ? 0 : (c <= 10) ? c - 7 : -1;
        end
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_valid  = (k < 4);
            idx       = IW'(k);
            out_ready = !(c >= 2 && c <= 6);
            #1;
            total++;
            if (in_ready !== exp_rdy[c]) begin
                bad++;
                $display("FAIL bp_in_ready c=%0d: got %b want %b", c, in_ready, exp_rdy[c]);
            end
            total++;
            if (out_valid !== (exp_item[c] >= 0)) begin
                bad++;
                $display("FAIL bp_valid c=%0d: got %b want %b", c, out_valid, exp_item[c] >= 0);
            end else if (exp_item[c] >= 0 && out !== exp_tab[exp_item[c]]) begin
                bad++;
                $display("FAIL bp_data c=%0d: got %h want %h", c, out, exp_tab[exp_item[c]]);
            end
            if (in_valid && in_ready) k++;
        end
    endtask

    task automatic test_mid_reset;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid  = (c < 2);
            idx       = (c == 0) ? 3'd5 : 3'd1;
            out_ready = 1'b0;
        end
        #1;
        total++;
        if (out_valid !== 1'b1 || out_oob !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_full: got valid=%b oob=%b in_ready=%b want 1/1/0",
                     out_valid, out_oob, in_ready);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out !== '0 || out_oob !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear: got valid=%b out=%h oob=%b want 0/0/0",
                     out_valid, out, out_oob);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midrst_stale c=%0d: got valid=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random;
        logic [EW:0]   sb [$];
        logic [EW:0]   exp_v;
        logic [EW-1:0] el;
        int            sent;
        int            cyc;
        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            idx       = IW'($urandom_range(7));
            for (int e = 0; e < NE; e++) begin
                x[e*EW +: EW] = {1'($urandom), $urandom};
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: got %h oob=%b with nothing expected", out, out_oob);
                end else begin
                    exp_v = sb.pop_front();
                    if ({out_oob, out} !== exp_v) begin
                        bad++;
                        $display("FAIL rand_data: got oob=%b out=%h want oob=%b out=%h",
                                 out_oob, out, exp_v[EW], exp_v[EW-1:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (idx < 3'd4) el = x[int'(idx)*EW +: EW];
                else            el = x[3*EW +: EW];
                sb.push_back({(idx >= 3'd4), el});
                sent++;
            end
        end
        total++;
        if (sb.size() != 0 || sent != 10000) begin
            bad++;
            $display("FAIL rand_timeout: got sent=%0d pending=%0d want 10000/0", sent, sb.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        x        = XV;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_stream();
        test_oob();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
